// File: rtl/vx_smem_serializer.sv
// rtl/vx_smem_serializer.sv - shared-memory bank serializer: per-lane bank issue, read gather, batch response
module vx_smem_serializer #(
    parameter int LANES      = 4,
    parameter int NUM_BANKS  = 4,
    parameter int DATA_SIZE  = 4,
    parameter int ADDR_WIDTH = 30,
    parameter int TAG_WIDTH  = 8,
    localparam int DATA_WIDTH      = 8 * DATA_SIZE,
    localparam int LOG_BANKS       = $clog2(NUM_BANKS),
    localparam int LANE_BITS       = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int BANK_ADDR_WIDTH = ADDR_WIDTH - LOG_BANKS
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [LANES-1:0]                     req_valid,
    input  logic [LANES-1:0]                     req_rw,
    input  logic [LANES*DATA_SIZE-1:0]           req_byteen,
    input  logic [LANES*ADDR_WIDTH-1:0]          req_addr,
    input  logic [LANES*DATA_WIDTH-1:0]          req_data,
    input  logic [LANES*TAG_WIDTH-1:0]           req_tag,
    output logic [LANES-1:0]                     req_ready,
    output logic [NUM_BANKS-1:0]                 bank_req_valid,
    output logic [NUM_BANKS-1:0]                 bank_req_rw,
    output logic [NUM_BANKS*DATA_SIZE-1:0]       bank_req_byteen,
    output logic [NUM_BANKS*BANK_ADDR_WIDTH-1:0] bank_req_addr,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]      bank_req_data,
    output logic [NUM_BANKS*LANE_BITS-1:0]       bank_req_lane,
    input  logic [NUM_BANKS-1:0]                 bank_req_ready,
    input  logic [NUM_BANKS-1:0]                 bank_rsp_valid,
    input  logic [NUM_BANKS*LANE_BITS-1:0]       bank_rsp_lane,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]      bank_rsp_data,
    output logic                                 rsp_valid,
    output logic [LANES-1:0]                     rsp_tmask,
    output logic [LANES*DATA_WIDTH-1:0]          rsp_data,
    output logic [TAG_WIDTH-1:0]                 rsp_tag,
    input  logic                                 rsp_ready
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                 state;
    logic [LANES-1:0]       pending;
    logic [LANES-1:0]       outstanding;
    logic [LANES-1:0]       vmask;
    logic                   rw_r;
    logic [TAG_WIDTH-1:0]   tag_r;
    logic [ADDR_WIDTH-1:0]  addr_r   [LANES];
    logic [DATA_WIDTH-1:0]  data_r   [LANES];
    logic [DATA_SIZE-1:0]   byteen_r [LANES];
    logic [DATA_WIDTH-1:0]  rdata_r  [LANES];

    logic                   first_rw;
    logic [TAG_WIDTH-1:0]   first_tag;
    logic                   first_found;
    logic [NUM_BANKS-1:0]   sel_valid;
    logic [LANE_BITS-1:0]   sel_lane [NUM_BANKS];
    logic [LANES-1:0]       grant;
    logic [LANES-1:0]       rsp_hit;
    logic [NUM_BANKS-1:0]   rsp_claimed;
    logic [DATA_WIDTH-1:0]  rsp_wdata [LANES];
    logic [LANES-1:0]       pending_n;
    logic [LANES-1:0]       outstanding_n;

    // Batch-wide rw and tag come from the lowest valid lane.
    always_comb begin
        first_rw    = 1'b0;
        first_tag   = '0;
        first_found = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (req_valid[l] && !first_found) begin
                first_rw    = req_rw[l];
                first_tag   = req_tag[l*TAG_WIDTH +: TAG_WIDTH];
                first_found = 1'b1;
            end
        end
    end

    // Per bank: lowest pending lane mapped to that bank wins this cycle.
    always_comb begin
        grant = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            sel_valid[b] = 1'b0;
            sel_lane[b]  = '0;
            for (int l = 0; l < LANES; l++) begin
                if (state == S_ISSUE && pending[l] && !sel_valid[b]
                    && addr_r[l][LOG_BANKS-1:0] == LOG_BANKS'(b)) begin
                    sel_valid[b] = 1'b1;
                    sel_lane[b]  = LANE_BITS'(l);
                end
            end
            if (sel_valid[b] && bank_req_ready[b])
                grant[sel_lane[b]] = 1'b1;
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_req_valid[b] = sel_valid[b];
            bank_req_rw[b]    = rw_r;
            bank_req_byteen[b*DATA_SIZE +: DATA_SIZE]             = byteen_r[sel_lane[b]];
            bank_req_addr[b*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH]   = addr_r[sel_lane[b]][ADDR_WIDTH-1:LOG_BANKS];
            bank_req_data[b*DATA_WIDTH +: DATA_WIDTH]             = data_r[sel_lane[b]];
            bank_req_lane[b*LANE_BITS +: LANE_BITS]               = sel_lane[b];
        end
    end

    // Responses only land on lanes still marked outstanding; anything else is dropped.
    always_comb begin
        rsp_hit     = '0;
        rsp_claimed = '0;
        for (int l = 0; l < LANES; l++)
            rsp_wdata[l] = rdata_r[l];
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int l = 0; l < LANES; l++) begin
                if (bank_rsp_valid[b] && outstanding[l]
                    && bank_rsp_lane[b*LANE_BITS +: LANE_BITS] == LANE_BITS'(l)) begin
                    rsp_hit[l]     = 1'b1;
                    rsp_claimed[b] = 1'b1;
                    rsp_wdata[l]   = bank_rsp_data[b*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        pending_n     = pending & ~grant;
        outstanding_n = (outstanding & ~rsp_hit) | (rw_r ? '0 : grant);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pending     <= '0;
            outstanding <= '0;
            vmask       <= '0;
            rw_r        <= 1'b0;
            tag_r       <= '0;
            for (int l = 0; l < LANES; l++) begin
                addr_r[l]   <= '0;
                data_r[l]   <= '0;
                byteen_r[l] <= '0;
                rdata_r[l]  <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        pending     <= req_valid;
                        vmask       <= req_valid;
                        outstanding <= '0;
                        rw_r        <= first_rw;
                        tag_r       <= first_tag;
                        for (int l = 0; l < LANES; l++) begin
                            addr_r[l]   <= req_addr[l*ADDR_WIDTH +: ADDR_WIDTH];
                            data_r[l]   <= req_data[l*DATA_WIDTH +: DATA_WIDTH];
                            byteen_r[l] <= req_byteen[l*DATA_SIZE +: DATA_SIZE];
                            rdata_r[l]  <= '0;
                        end
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    pending     <= pending_n;
                    outstanding <= outstanding_n;
                    for (int l = 0; l < LANES; l++)
                        rdata_r[l] <= rsp_wdata[l];
                    if (pending_n == '0)
                        state <= rw_r ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    outstanding <= outstanding_n;
                    for (int l = 0; l < LANES; l++)
                        rdata_r[l] <= rsp_wdata[l];
                    if (outstanding_n == '0)
                        state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = {LANES{state == S_IDLE}};
    assign rsp_valid = (state == S_RESP);
    assign rsp_tmask = (state == S_RESP) ? vmask : '0;
    assign rsp_tag   = tag_r;

    always_comb begin
        for (int l = 0; l < LANES; l++)
            rsp_data[l*DATA_WIDTH +: DATA_WIDTH] = rdata_r[l];
    end

    always @(posedge clk) begin
        if (reset && state == S_IDLE) begin
            for (int l = 0; l < LANES; l++) begin
                if (req_valid[l]) begin
                    assert (req_rw[l] == first_rw && req_tag[l*TAG_WIDTH +: TAG_WIDTH] == first_tag)
                        else $error("vx_smem_serializer: lane %0d rw/tag disagree with lowest valid lane", l);
                end
            end
        end
        if (reset && |outstanding) begin
            assert ((bank_rsp_valid & ~rsp_claimed) == '0)
                else $error("vx_smem_serializer: bank response for a lane with no outstanding read");
        end
    end

endmodule

// File: tb/tb_vx_smem_serializer.sv
// tb/tb_vx_smem_serializer.sv - directed and randomized bench for vx_smem_serializer with bank memory model
module tb_vx_smem_serializer;

    localparam int LANES = 4;
    localparam int NB    = 4;
    localparam int DS    = 4;
    localparam int AW    = 30;
    localparam int TW    = 8;
    localparam int DW    = 32;
    localparam int LB    = 2;
    localparam int BAW   = 28;

    logic                clk = 1'b0;
    logic                reset;
    logic [LANES-1:0]    req_valid;
    logic [LANES-1:0]    req_rw;
    logic [LANES*DS-1:0] req_byteen;
    logic [LANES*AW-1:0] req_addr;
    logic [LANES*DW-1:0] req_data;
    logic [LANES*TW-1:0] req_tag;
    logic [LANES-1:0]    req_ready;
    logic [NB-1:0]       bank_req_valid;
    logic [NB-1:0]       bank_req_rw;
    logic [NB*DS-1:0]    bank_req_byteen;
    logic [NB*BAW-1:0]   bank_req_addr;
    logic [NB*DW-1:0]    bank_req_data;
    logic [NB*LB-1:0]    bank_req_lane;
    logic [NB-1:0]       bank_req_ready;
    logic [NB-1:0]       bank_rsp_valid;
    logic [NB*LB-1:0]    bank_rsp_lane;
    logic [NB*DW-1:0]    bank_rsp_data;
    logic                rsp_valid;
    logic [LANES-1:0]    rsp_tmask;
    logic [LANES*DW-1:0] rsp_data;
    logic [TW-1:0]       rsp_tag;
    logic                rsp_ready;

    vx_smem_serializer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_rw(req_rw), .req_byteen(req_byteen),
        .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready),
        .bank_req_valid(bank_req_valid), .bank_req_rw(bank_req_rw), .bank_req_byteen(bank_req_byteen),
        .bank_req_addr(bank_req_addr), .bank_req_data(bank_req_data), .bank_req_lane(bank_req_lane),
        .bank_req_ready(bank_req_ready),
        .bank_rsp_valid(bank_rsp_valid), .bank_rsp_lane(bank_rsp_lane), .bank_rsp_data(bank_rsp_data),
        .rsp_valid(rsp_valid), .rsp_tmask(rsp_tmask), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Reference memory by full word address; bank memory by (bank, in-bank address).
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] bmem [NB][16];
    int            lat [NB];

    typedef struct {int due; int bank; logic [LB-1:0] lane; logic [DW-1:0] data;} rsp_t;
    typedef struct {int cyc; int bank; int lane; logic rw;} iss_t;
    rsp_t rq[$];
    iss_t iss_q[$];

    int            ta [LANES];
    logic [DW-1:0] td [LANES];
    logic [DS-1:0] tbe [LANES];
    logic [DW-1:0] exp_data [LANES];
    logic [3:0]    exp_vm;
    logic [7:0]    exp_tag;
    logic          rand_ready = 1'b0;

    // Bank model: accepts handshakes, performs writes, returns reads after lat[b] cycles.
    always @(negedge clk) begin : bank_model
        int ba;
        for (int b = 0; b < NB; b++) begin
            if (bank_req_valid[b] && bank_req_ready[b]) begin
                ba = int'(bank_req_addr[b*BAW +: BAW]);
                iss_q.push_back('{cyc, b, int'(bank_req_lane[b*LB +: LB]), bank_req_rw[b]});
                if (ba < 16) begin
                    if (bank_req_rw[b]) begin
                        for (int by = 0; by < DS; by++)
                            if (bank_req_byteen[b*DS + by])
                                bmem[b][ba][8*by +: 8] = bank_req_data[b*DW + 8*by +: 8];
                    end else begin
                        rq.push_back('{cyc + lat[b], b, bank_req_lane[b*LB +: LB], bmem[b][ba]});
                    end
                end
            end
        end
        bank_rsp_valid = '0;
        bank_rsp_lane  = '0;
        bank_rsp_data  = '0;
        for (int i = rq.size() - 1; i >= 0; i--) begin
            if (rq[i].due == cyc) begin
                bank_rsp_valid[rq[i].bank]                = 1'b1;
                bank_rsp_lane[rq[i].bank*LB +: LB]        = rq[i].lane;
                bank_rsp_data[rq[i].bank*DW +: DW]        = rq[i].data;
                rq.delete(i);
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bank_req_ready = 4'($urandom);
    endtask

    function automatic logic [127:0] exp_pk();
        logic [127:0] v;
        for (int l = 0; l < LANES; l++) v[l*DW +: DW] = exp_data[l];
        return v;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send(input logic [3:0] vm, input logic rw, input logic [7:0] tag, output int acc);
        for (int l = 0; l < LANES; l++) begin
            req_addr[l*AW +: AW]   = AW'(ta[l]);
            req_data[l*DW +: DW]   = td[l];
            req_byteen[l*DS +: DS] = tbe[l];
        end
        req_rw    = {LANES{rw}};
        req_tag   = {LANES{tag}};
        req_valid = vm;
        @(negedge clk);
        chk("accept_ready", 128'(req_ready), 128'hF);
        acc = cyc;
        tick();
        req_valid = '0;
        for (int l = 0; l < LANES; l++) begin
            exp_data[l] = '0;
            if (vm[l]) begin
                if (rw) begin
                    for (int by = 0; by < DS; by++)
                        if (tbe[l][by]) ref_mem[ta[l]][8*by +: 8] = td[l][8*by +: 8];
                end else begin
                    exp_data[l] = ref_mem[ta[l]];
                end
            end
        end
        exp_vm  = vm;
        exp_tag = tag;
    endtask

    task automatic wait_rsp(input int hold, output int rc);
        int n = 0;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && n < 200) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk("rsp_arrives", 128'(rsp_valid), 128'h1);
        rc = cyc;
        for (int h = 0; h < hold; h++) begin
            tick();
            @(negedge clk);
            chk("rsp_held_valid", 128'(rsp_valid), 128'h1);
            chk("rsp_held_data", rsp_data, exp_pk());
        end
        chk("rsp_tmask", 128'(rsp_tmask), 128'(exp_vm));
        chk("rsp_tag", 128'(rsp_tag), 128'(exp_tag));
        chk("rsp_data", rsp_data, exp_pk());
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_valid_at_hs", 128'(rsp_valid), 128'h1);
        tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("rsp_done", 128'(rsp_valid), 128'h0);
        chk("ready_after_rsp", 128'(req_ready), 128'hF);
    endtask

    task automatic wait_write_done(output int dc);
        int n = 0;
        @(negedge clk);
        chk("wr_no_rsp", 128'(rsp_valid), 128'h0);
        while (req_ready !== 4'hF && n < 100) begin
            tick();
            @(negedge clk);
            chk("wr_no_rsp", 128'(rsp_valid), 128'h0);
            n++;
        end
        chk("wr_done", 128'(req_ready), 128'hF);
        dc = cyc;
    endtask

    initial begin
        int acc, rc, dc, cnt;
        logic [3:0] vm;
        logic       rw;
        logic [7:0] tag;

        for (int a = 0; a < 64; a++) begin
            ref_mem[a] = $urandom;
            bmem[a % NB][a / NB] = ref_mem[a];
        end
        for (int b = 0; b < NB; b++) lat[b] = 1;
        reset = 1'b0;
        req_valid = '0; req_rw = '0; req_byteen = '0; req_addr = '0; req_data = '0; req_tag = '0;
        bank_req_ready = '1;
        rsp_ready = 1'b0;
        bank_rsp_valid = '0; bank_rsp_lane = '0; bank_rsp_data = '0;
        for (int l = 0; l < LANES; l++) tbe[l] = 4'hF;

        @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 128'(req_ready), 128'hF);
        chk("rst_bank_valid", 128'(bank_req_valid), 128'h0);
        chk("rst_rsp_valid", 128'(rsp_valid), 128'h0);
        chk("rst_rsp_tmask", 128'(rsp_tmask), 128'h0);
        chk("rst_rsp_data", rsp_data, 128'h0);
        chk("rst_rsp_tag", 128'(rsp_tag), 128'h0);
        tick();
        reset = 1'b1;

        // Conflict-free read, latency 1
        tick();
        for (int l = 0; l < LANES; l++) begin ta[l] = l; td[l] = $urandom; end
        iss_q.delete();
        send(4'hF, 1'b0, 8'hA5, acc);
        wait_rsp(0, rc);
        chk("t1_latency", 128'(rc - acc), 128'd3);
        cnt = 0;
        foreach (iss_q[i]) if (iss_q[i].cyc == acc + 1) cnt++;
        chk("t1_one_issue_cycle", 128'(cnt), 128'd4);

        // All lanes on bank 0
        tick();
        for (int l = 0; l < LANES; l++) ta[l] = 4 * l;
        iss_q.delete();
        send(4'hF, 1'b0, 8'h3C, acc);
        wait_rsp(0, rc);
        chk("t2_iss_count", 128'(iss_q.size()), 128'd4);
        for (int i = 0; i < iss_q.size() && i < 4; i++) begin
            chk("t2_iss_cyc", 128'(iss_q[i].cyc - acc), 128'(i + 1));
            chk("t2_iss_lane", 128'(iss_q[i].lane), 128'(i));
            chk("t2_iss_bank", 128'(iss_q[i].bank), 128'd0);
        end

        // Write lanes 0,2 to banks 1,2
        tick();
        ta[0] = 5; ta[1] = 0; ta[2] = 6; ta[3] = 0;
        for (int l = 0; l < LANES; l++) td[l] = $urandom;
        iss_q.delete();
        send(4'b0101, 1'b1, 8'h11, acc);
        wait_write_done(dc);
        chk("t3_done_cycle", 128'(dc - acc), 128'd2);
        chk("t3_iss_count", 128'(iss_q.size()), 128'd2);
        for (int i = 0; i < iss_q.size() && i < 2; i++) begin
            chk("t3_iss_cyc", 128'(iss_q[i].cyc - acc), 128'd1);
            chk("t3_iss_bank", 128'(iss_q[i].bank), 128'(i + 1));
            chk("t3_iss_lane", 128'(iss_q[i].lane), 128'(2 * i));
            chk("t3_iss_rw", 128'(iss_q[i].rw), 128'h1);
        end

        // Bank 1 stalled for 3 cycles
        tick();
        for (int l = 0; l < LANES; l++) ta[l] = 16 + l;
        ta[1] = 5;
        bank_req_ready = 4'b1101;
        iss_q.delete();
        send(4'hF, 1'b0, 8'h77, acc);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_b1_valid", 128'(bank_req_valid[1]), 128'h1);
            chk("t4_b1_addr", 128'(bank_req_addr[BAW +: BAW]), 128'd1);
            chk("t4_b1_lane", 128'(bank_req_lane[LB +: LB]), 128'd1);
            tick();
        end
        bank_req_ready = '1;
        wait_rsp(0, rc);
        chk("t4_latency", 128'(rc - acc), 128'd6);
        foreach (iss_q[i])
            chk("t4_iss_cyc", 128'(iss_q[i].cyc - acc), 128'((iss_q[i].bank == 1) ? 4 : 1));

        // Out-of-order responses with rsp_ready held low
        tick();
        for (int l = 0; l < LANES; l++) ta[l] = 32 + l;
        lat[0] = 4; lat[1] = 3; lat[2] = 2; lat[3] = 1;
        send(4'hF, 1'b0, 8'hC3, acc);
        wait_rsp(2, rc);
        chk("t5_latency", 128'(rc - acc), 128'd6);

        // Reset while two reads are outstanding
        tick();
        for (int b = 0; b < NB; b++) lat[b] = 5;
        ta[0] = 8; ta[1] = 9; ta[2] = 0; ta[3] = 0;
        send(4'b0011, 1'b0, 8'h5A, acc);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("t6_req_ready", 128'(req_ready), 128'hF);
        chk("t6_bank_valid", 128'(bank_req_valid), 128'h0);
        chk("t6_rsp_valid", 128'(rsp_valid), 128'h0);
        chk("t6_rsp_tmask", 128'(rsp_tmask), 128'h0);
        chk("t6_rsp_data", rsp_data, 128'h0);
        chk("t6_rsp_tag", 128'(rsp_tag), 128'h0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t6_late_ignored", 128'(rsp_valid), 128'h0);
            chk("t6_idle", 128'(req_ready), 128'hF);
            tick();
        end
        for (int b = 0; b < NB; b++) lat[b] = 1;
        for (int l = 0; l < LANES; l++) ta[l] = 12 + l;
        send(4'hF, 1'b0, 8'h99, acc);
        wait_rsp(0, rc);
        chk("t6_next_latency", 128'(rc - acc), 128'd3);

        // Randomized batches against the reference memory
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            vm  = 4'($urandom_range(1, 15));
            rw  = ($urandom % 3 == 0);
            tag = 8'($urandom);
            for (int l = 0; l < LANES; l++) begin
                ta[l]  = $urandom_range(0, 63);
                td[l]  = $urandom;
                tbe[l] = 4'($urandom);
            end
            for (int b = 0; b < NB; b++) lat[b] = $urandom_range(1, 4);
            tick();
            send(vm, rw, tag, acc);
            if (rw) wait_write_done(dc);
            else    wait_rsp($urandom_range(0, 2), rc);
        end

        // Read back every address to confirm all writes reached the right bank words
        rand_ready = 1'b0;
        bank_req_ready = '1;
        for (int base = 0; base < 64; base += 4) begin
            for (int l = 0; l < LANES; l++) ta[l] = base + l;
            tick();
            send(4'hF, 1'b0, 8'(base), acc);
            wait_rsp(0, rc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
